func_result_buf: RTL and testbench
==================================

# func_result_buf

Parametrised result buffer and scoreboard for the pipelined convertTo/convertFrom operators. It tracks issued operations through a configurable-latency valid/address delay line and captures each operator result into a dual-port result array when the result retires. Each entry carries a pending-write counter, so `ready` stays low until the last of several overlapping writes to the same address has landed. It also rejects issues that would overflow the counter.

## Interface
- `ADDRS_WIDTH`, 4, result-array address width; depth = 2^ADDRS_WIDTH entries.
- `DATA_WIDTH`, 274, result width (exception code plus character string).
- `LATENCY`, 17, operator pipeline depth in clocks; legal range is 1 or more.
- `PEND_WIDTH`, 2, width of each per-entry pending counter; maximum value PMAX = 2^PEND_WIDTH-1.

Ports:
- `CLK`, in, 1: single clock, rising edge.
- `RESET`, in, 1: asynchronous, active-low reset.
- `wren`, in, 1: issue strobe; one operation enters the operator this cycle.
- `wraddrs`, in, ADDRS_WIDTH: destination entry of the issued operation.
- `resdata`, in, DATA_WIDTH: operator result for the operation issued LATENCY cycles earlier.
- `rden`, in, 1: read request.
- `rdaddrs`, in, ADDRS_WIDTH: entry to read.
- `rddata`, out, DATA_WIDTH: registered read data.
- `ready`, out, 1: registered; 1 means `rddata` is final for the entry read.
- `wr_full`, out, 1: combinational; pending[wraddrs] == PMAX.
- `overflow`, out, 1: sticky; set when an issue is rejected.

## Operation
- Delay line has LATENCY stages of {valid, addr}.
  - Stage 0 loads {wren & ~wr_full, wraddrs}.
  - The last stage drives retire valid `rv` and retire address `ra`.
- Accepted issue (`wren & ~wr_full`): pending[wraddrs] += 1.
- Rejected issue (`wren & wr_full`): no delay-line entry, pending unchanged, `overflow` <= 1.
- Retire (`rv`): mem[ra] <= resdata; pending[ra] -= 1.
- Accepted issue and retire to the same entry in the same cycle: pending is unchanged (net 0).
- Pending never underflows. Underflow cannot occur by construction; add an assertion that pending[ra] != 0 when `rv`.
- Read (`rden`), registered, write-first:
  - If `rv` and ra == rdaddrs in the same cycle, `rddata` <= resdata; otherwise `rddata` <= mem[rdaddrs].
- `ready` <= rden ? (pending_next[rdaddrs] == 0) : 1.
  - pending_next is the post-update count, including same-cycle issue and retire.
  - With `rden` low, `ready` returns to 1 and `rddata` holds its value.
- Reset (asynchronous, RESET = 0):
  - Clears all delay-line valid bits and all pending counters.
  - `ready` = 1, `rddata` = 0, `overflow` = 0.
  - Array contents are not reset. Entries never written read as X.
- Reset mid-operation: in-flight results are discarded and never written. Entries read ready = 1 afterwards.
- `overflow` clears only on reset.

## Timing
- Issue sampled at edge T; pending increments at edge T.
- `resdata` must be valid during the cycle ending at edge T+LATENCY; captured at edge T+LATENCY.
- Read sampled at edge R. `rddata` and `ready` are valid after edge R, i.e. one-cycle read latency.
- Throughput: one issue, one retire and one read per clock, all independent.
- `wr_full` is purely combinational from pending state and `wraddrs`; there is no registered path.
- A read of entry A issued in the same cycle as the issue to A returns `ready` = 0.
- A read sampled at edge T+LATENCY (the retire edge) returns the new data with `ready` = 1, provided no other writes to A are pending.

## Test plan
Defaults used throughout.
- **Reset state:** hold RESET low 3 cycles, release, then read entry 5 -> `ready` = 1, `overflow` = 0; `rddata` = 0 before the first read.
- **Basic latency:**
  - Stimulus: issue to 3 at cycle 10, drive `resdata` = 274'h1_ABCD at the cycle-27 edge.
  - Reads of 3 at cycles 11..26 -> `ready` = 0.
  - Read at cycle 27 -> `ready` = 1, `rddata` = 274'h1_ABCD (write-first bypass).
- **Overlapping writes:**
  - Stimulus: issue to 7 at cycles 0 and 4 with results 'h11 and 'h22.
  - Read at 18 -> `ready` = 0, `rddata` = 'h11.
  - Read at 21 -> `ready` = 1, `rddata` = 'h22.
- **Saturation:**
  - Stimulus: issue to 2 on cycles 0..3.
  - Cycle 3 sees `wr_full` = 1, the issue is rejected, and `overflow` = 1 from cycle 4 onward.
  - Only 3 retires occur, on cycles 17..19. pending[2] = 0 after cycle 19.
- **Simultaneous events:**
  - Stimulus: issue to 9 at cycle 0; at cycle 17 issue to 9 again and read 9.
  - Cycle-17 read -> `ready` = 0 (net pending 1) with the first result in `rddata`.
  - Read at cycle 34 -> `ready` = 1.
- **Reset mid-flight:**
  - Stimulus: issue to 4 at cycle 0, assert RESET for cycles 5..6, drive `resdata` = 'hFF at cycle 17.
  - Entry 4 is not written, and a read at 20 -> `ready` = 1.

Source files
------------

// File: rtl/func_result_buf.sv
// Result buffer and scoreboard for the pipelined convert operators: tracks in-flight
// operations through a delay line and holds each result until its last pending write lands.
module func_result_buf #(
  parameter int ADDRS_WIDTH = 4,
  parameter int DATA_WIDTH  = 274,
  parameter int LATENCY     = 17,
  parameter int PEND_WIDTH  = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   wren,
  input  logic [ADDRS_WIDTH-1:0] wraddrs,
  input  logic [DATA_WIDTH-1:0]  resdata,
  input  logic                   rden,
  input  logic [ADDRS_WIDTH-1:0] rdaddrs,
  output logic [DATA_WIDTH-1:0]  rddata,
  output logic                   ready,
  output logic                   wr_full,
  output logic                   overflow
);

  localparam int DEPTH = 1 << ADDRS_WIDTH;
  localparam logic [PEND_WIDTH-1:0] PMAX = '1;

  logic [LATENCY-1:0]     dl_v_q;
  logic [ADDRS_WIDTH-1:0] dl_a_q [LATENCY];
  logic [PEND_WIDTH-1:0]  pend_q [DEPTH];
  logic [PEND_WIDTH-1:0]  pend_d [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0]  rddata_q, rddata_d;
  logic                   ready_q, ready_d;
  logic                   overflow_q;
  logic                   accept, rv;
  logic [ADDRS_WIDTH-1:0] ra;

  assign wr_full  = (pend_q[wraddrs] == PMAX);
  assign accept   = wren & ~wr_full;
  assign rv       = dl_v_q[LATENCY-1];
  assign ra       = dl_a_q[LATENCY-1];
  assign rddata   = rddata_q;
  assign ready    = ready_q;
  assign overflow = overflow_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      dl_v_q <= '0;
      dl_a_q <= '{default: '0};
    end else begin
      dl_v_q[0] <= accept;
      dl_a_q[0] <= wraddrs;
      for (int k = 1; k < LATENCY; k++) begin
        dl_v_q[k] <= dl_v_q[k-1];
        dl_a_q[k] <= dl_a_q[k-1];
      end
    end
  end

  // Issue and retire to the same entry in one cycle cancel out.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      pend_d[i] = pend_q[i];
      if (accept && (wraddrs == ADDRS_WIDTH'(i))) pend_d[i] = pend_d[i] + PEND_WIDTH'(1);
      if (rv && (ra == ADDRS_WIDTH'(i)))          pend_d[i] = pend_d[i] - PEND_WIDTH'(1);
    end
  end

  always_comb begin
    rddata_d = rddata_q;
    ready_d  = 1'b1;
    if (rden) begin
      rddata_d = (rv && (ra == rdaddrs)) ? resdata : mem_q[rdaddrs];
      ready_d  = (pend_d[rdaddrs] == '0);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pend_q     <= '{default: '0};
      rddata_q   <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      rddata_q   <= rddata_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_q | (wren & wr_full);
    end
  end

  // Array contents survive reset; in-flight results die with their valid bits.
  always_ff @(posedge CLK) begin
    if (rv) mem_q[ra] <= resdata;
  end

  a_no_underflow: assert property (@(posedge CLK) disable iff (!RESET) rv |-> (pend_q[ra] != '0));

endmodule

// File: tb/tb_func_result_buf.sv
// Directed bench for func_result_buf; reads push expectations, a monitor checks them.
module tb_func_result_buf;

  localparam int AW = 4;
  localparam int DW = 274;

  typedef struct {
    logic          chk_d;
    logic [DW-1:0] d;
    logic          r;
    string         name;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          wren = 1'b0;
  logic [AW-1:0] wraddrs = '0;
  logic [DW-1:0] resdata = '0;
  logic          rden = 1'b0;
  logic [AW-1:0] rdaddrs = '0;
  logic [DW-1:0] rddata;
  logic          ready, wr_full, overflow;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb_q[$];

  func_result_buf #(.ADDRS_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(17), .PEND_WIDTH(2)) dut (
    .CLK(CLK), .RESET(RESET), .wren(wren), .wraddrs(wraddrs), .resdata(resdata),
    .rden(rden), .rdaddrs(rdaddrs), .rddata(rddata), .ready(ready),
    .wr_full(wr_full), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    wren = 1'b0; rden = 1'b0; resdata = '0;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    wren = 1'b1; wraddrs = a;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic cd, input logic [DW-1:0] d,
                    input logic r, input string name);
    exp_t e;
    rden = 1'b1; rdaddrs = a;
    e.chk_d = cd; e.d = d; e.r = r; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    idle();
    RESET = 1'b0;
    repeat (3) tick();
    RESET = 1'b1;
  endtask

  // Monitor: one expectation per read sampled at a clock edge
  initial begin
    logic seen;
    exp_t e;
    forever begin
      @(posedge CLK);
      seen = rden && RESET;
      @(negedge CLK);
      if (seen) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_empty: got read with no expectation, expected queued entry");
        end else begin
          e = sb_q.pop_front();
          chk({e.name, "_ready"}, DW'(ready), DW'(e.r));
          if (e.chk_d) chk({e.name, "_data"}, rddata, e.d);
        end
      end
    end
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_rddata", rddata, '0);
    chk("rst_ready", DW'(ready), DW'(1));
    chk("rst_overflow", DW'(overflow), DW'(0));
    rd(4'd5, 1'b0, '0, 1'b1, "rst_read5");
    tick(); idle(); tick();

    // Basic latency with write-first bypass on the retire edge
    for (int c = 0; c <= 17; c++) begin
      idle();
      if (c == 0) begin
        issue(4'd3); #1;
        chk("lat_wr_full", DW'(wr_full), DW'(0));
      end
      if (c >= 1 && c <= 16) rd(4'd3, 1'b0, '0, 1'b0, "lat_wait");
      if (c == 17) begin
        resdata = DW'(20'h1_ABCD);
        rd(4'd3, 1'b1, DW'(20'h1_ABCD), 1'b1, "lat_bypass");
      end
      tick();
    end
    idle(); tick(); tick();

    // Overlapping writes to entry 7
    do_reset();
    for (int c = 0; c <= 21; c++) begin
      idle();
      if (c == 0 || c == 4) issue(4'd7);
      if (c == 17) begin resdata = DW'(8'h11); rd(4'd7, 1'b1, DW'(8'h11), 1'b0, "ovl_c17"); end
      if (c == 18) rd(4'd7, 1'b1, DW'(8'h11), 1'b0, "ovl_c18");
      if (c == 21) begin resdata = DW'(8'h22); rd(4'd7, 1'b1, DW'(8'h22), 1'b1, "ovl_c21"); end
      tick();
    end
    idle(); tick(); tick();

    // Saturation of entry 2
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      idle();
      if (c <= 3) begin
        issue(4'd2); #1;
        chk($sformatf("sat_wr_full_c%0d", c), DW'(wr_full), DW'(c == 3));
      end
      if (c == 3) chk("sat_overflow_pre", DW'(overflow), DW'(0));
      if (c == 4) chk("sat_overflow_post", DW'(overflow), DW'(1));
      if (c == 17) resdata = DW'(8'h0A);
      if (c == 18) begin resdata = DW'(8'h0B); rd(4'd2, 1'b1, DW'(8'h0B), 1'b0, "sat_c18"); end
      if (c == 19) begin resdata = DW'(8'h0C); rd(4'd2, 1'b1, DW'(8'h0C), 1'b1, "sat_c19"); end
      if (c == 20) begin resdata = DW'(8'hDD); rd(4'd2, 1'b1, DW'(8'h0C), 1'b1, "sat_c20"); end
      tick();
    end
    idle(); wraddrs = 4'd2; #1;
    chk("sat_wr_full_end", DW'(wr_full), DW'(0));
    chk("sat_overflow_sticky", DW'(overflow), DW'(1));
    tick(); tick();

    // Simultaneous issue, retire and read on entry 9
    do_reset();
    for (int c = 0; c <= 34; c++) begin
      idle();
      if (c == 0) issue(4'd9);
      if (c == 17) begin
        issue(4'd9); resdata = DW'(8'h55);
        rd(4'd9, 1'b1, DW'(8'h55), 1'b0, "sim_c17");
      end
      if (c == 34) begin resdata = DW'(8'h66); rd(4'd9, 1'b1, DW'(8'h66), 1'b1, "sim_c34"); end
      tick();
    end
    idle(); tick(); tick();

    // Reset mid-flight: prefill entry 4, then lose an in-flight result
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      idle();
      if (c == 0) issue(4'd4);
      if (c == 17) resdata = DW'(8'h44);
      tick();
    end
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      idle();
      if (c == 0) issue(4'd4);
      if (c == 5) RESET = 1'b0;
      if (c == 7) RESET = 1'b1;
      if (c == 17) begin resdata = DW'(8'hFF); rd(4'd4, 1'b1, DW'(8'h44), 1'b1, "rmf_c17"); end
      if (c == 20) rd(4'd4, 1'b1, DW'(8'h44), 1'b1, "rmf_c20");
      tick();
    end
    idle(); tick(); tick();

    chk("sb_drained", DW'(sb_q.size()), DW'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
